// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment scan capture block.
// Patterns are active-low, ordered {g,f,e,d,c,b,a} (bit0 = a).
package seg7_pkg;

  localparam int SEG_W = 7;
  localparam int NDIG  = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_pattern_dec.sv
// seg7_pattern_dec: combinational decode of one active-low segment pattern
// into a hex nibble, with hex-match and blank flags.
module seg7_pattern_dec
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pat_i,
  output logic [3:0]       nib_o,
  output logic             hex_o,
  output logic             blank_o
);

  // Table lookup; anything not in the table and not blank is an error pattern.
  always_comb begin
    nib_o   = 4'h0;
    hex_o   = 1'b1;
    blank_o = 1'b0;
    case (pat_i)
      SEG_0:     nib_o = 4'h0;
      SEG_1:     nib_o = 4'h1;
      SEG_2:     nib_o = 4'h2;
      SEG_3:     nib_o = 4'h3;
      SEG_4:     nib_o = 4'h4;
      SEG_5:     nib_o = 4'h5;
      SEG_6:     nib_o = 4'h6;
      SEG_7:     nib_o = 4'h7;
      SEG_8:     nib_o = 4'h8;
      SEG_9:     nib_o = 4'h9;
      SEG_A:     nib_o = 4'hA;
      SEG_B:     nib_o = 4'hB;
      SEG_C:     nib_o = 4'hC;
      SEG_D:     nib_o = 4'hD;
      SEG_E:     nib_o = 4'hE;
      SEG_F:     nib_o = 4'hF;
      SEG_BLANK: begin
        hex_o   = 1'b0;
        blank_o = 1'b1;
      end
      default:   hex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers hex digits from a multiplexed active-low
// 4-digit seven-segment bus and publishes complete frames with a valid pulse.
// Optional macro SEG7_DP_EN adds the decimal point input iDP and output oDP.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [SEG_W-1:0]  iSEG,
  input  logic [NDIG-1:0]   iDIG_SEL,
  input  logic              iCLR_ERR,
`ifdef SEG7_DP_EN
  input  logic              iDP,
  output logic [NDIG-1:0]   oDP,
`endif
  output logic [4*NDIG-1:0] oDIG,
  output logic [NDIG-1:0]   oBLANK,
  output logic              oVALID,
  output logic [NDIG-1:0]   oERR
);

`ifdef SEG7_DP_EN
  localparam int PAT_W = SEG_W + 1;
`else
  localparam int PAT_W = SEG_W;
`endif
  localparam logic [7:0]  CNT_MAX = 8'(STABLE_CNT);
  localparam logic [15:0] DIV_TC  = 16'(SAMPLE_DIV - 1);

  logic [SEG_W-1:0] seg_s1_q, seg_s2_q;
  logic [NDIG-1:0]  sel_s1_q, sel_s2_q;
  logic [15:0]      div_q;
  logic             sample_en;
  logic             sel_ok;
  logic [1:0]       sel_k;
  logic [PAT_W-1:0] pat_cur;
  logic [7:0]       cnt_q, cnt_d;
  logic             acc_q, acc_d, accept;
  logic [1:0]       prev_k_q, prev_k_d;
  logic [PAT_W-1:0] prev_pat_q, prev_pat_d;
  logic [3:0]       dec_nib;
  logic             dec_hex, dec_blank;
  logic             acc_v_q, acc_hex_q, acc_blank_q;
  logic [1:0]       acc_k_q;
  logic [3:0]       acc_nib_q;
  logic [NDIG-1:0][3:0] shadow_q, shadow_d, dig_q;
  logic [NDIG-1:0]  blank_sh_q, blank_sh_d, blank_q;
  logic [NDIG-1:0]  seen_q, seen_d, err_q, err_set;
  logic             valid_q, frame;
`ifdef SEG7_DP_EN
  logic             dp_s1_q, dp_s2_q, acc_dp_q;
  logic [NDIG-1:0]  dp_sh_q, dp_sh_d, dp_q;
`endif

  // Two-flop synchronizers; reset to all-ones so the bus looks idle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      sel_s1_q <= '1;
      sel_s2_q <= '1;
    end else begin
      seg_s1_q <= iSEG;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= iDIG_SEL;
      sel_s2_q <= sel_s1_q;
    end
  end

`ifdef SEG7_DP_EN
  // Decimal point travels through its own synchronizer alongside iSEG.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dp_s1_q <= 1'b1;
      dp_s2_q <= 1'b1;
    end else begin
      dp_s1_q <= iDP;
      dp_s2_q <= dp_s1_q;
    end
  end
  assign pat_cur = {dp_s2_q, seg_s2_q};
`else
  assign pat_cur = seg_s2_q;
`endif

  // Sample-rate divider: a sample is taken at terminal count.
  assign sample_en = (div_q == DIV_TC);
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)           div_q <= '0;
    else if (sample_en) div_q <= '0;
    else                div_q <= div_q + 16'd1;
  end

  // Select must be exactly one low strobe to be a usable sample.
  always_comb begin
    sel_ok = 1'b1;
    sel_k  = 2'd0;
    case (sel_s2_q)
      4'b1110: sel_k = 2'd0;
      4'b1101: sel_k = 2'd1;
      4'b1011: sel_k = 2'd2;
      4'b0111: sel_k = 2'd3;
      default: sel_ok = 1'b0;
    endcase
  end

  // Stability filter: count identical samples, accept once per strobe.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    prev_k_d   = prev_k_q;
    prev_pat_d = prev_pat_q;
    accept     = 1'b0;
    if (sample_en) begin
      if (!sel_ok) begin
        cnt_d = 8'd0;
        acc_d = 1'b0;
      end else if (sel_k != prev_k_q || pat_cur != prev_pat_q) begin
        cnt_d      = 8'd1;
        acc_d      = 1'b0;
        prev_k_d   = sel_k;
        prev_pat_d = pat_cur;
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
        if (cnt_d == CNT_MAX && !acc_q) begin
          accept = 1'b1;
          acc_d  = 1'b1;
        end
      end
    end
  end

  seg7_pattern_dec u_dec (
    .pat_i   (seg_s2_q),
    .nib_o   (dec_nib),
    .hex_o   (dec_hex),
    .blank_o (dec_blank)
  );

  // Filter state plus the registered decode of an accepted digit.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      prev_k_q    <= '0;
      prev_pat_q  <= '1;
      acc_v_q     <= 1'b0;
      acc_k_q     <= '0;
      acc_nib_q   <= '0;
      acc_hex_q   <= 1'b0;
      acc_blank_q <= 1'b0;
`ifdef SEG7_DP_EN
      acc_dp_q    <= 1'b1;
`endif
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      prev_k_q   <= prev_k_d;
      prev_pat_q <= prev_pat_d;
      acc_v_q    <= accept;
      if (accept) begin
        acc_k_q     <= sel_k;
        acc_nib_q   <= dec_nib;
        acc_hex_q   <= dec_hex;
        acc_blank_q <= dec_blank;
`ifdef SEG7_DP_EN
        acc_dp_q    <= dp_s2_q;
`endif
      end
    end
  end

  // Merge an accepted digit into the shadow frame; detect frame completion.
  always_comb begin
    shadow_d   = shadow_q;
    blank_sh_d = blank_sh_q;
    seen_d     = seen_q;
    err_set    = '0;
`ifdef SEG7_DP_EN
    dp_sh_d    = dp_sh_q;
`endif
    if (acc_v_q) begin
      if (acc_hex_q || acc_blank_q) begin
        shadow_d[acc_k_q]   = acc_hex_q ? acc_nib_q : 4'h0;
        blank_sh_d[acc_k_q] = acc_blank_q;
        seen_d[acc_k_q]     = 1'b1;
`ifdef SEG7_DP_EN
        dp_sh_d[acc_k_q]    = ~acc_dp_q;
`endif
      end else begin
        err_set[acc_k_q] = 1'b1;
      end
    end
    frame = (seen_d == '1);
  end

  // Shadow, frame publish and sticky error registers; error set beats clear.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shadow_q   <= '0;
      blank_sh_q <= '0;
      seen_q     <= '0;
      dig_q      <= '0;
      blank_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
`ifdef SEG7_DP_EN
      dp_sh_q    <= '0;
      dp_q       <= '0;
`endif
    end else begin
      shadow_q   <= shadow_d;
      blank_sh_q <= blank_sh_d;
      valid_q    <= frame;
      err_q      <= (err_q & ~{NDIG{iCLR_ERR}}) | err_set;
`ifdef SEG7_DP_EN
      dp_sh_q    <= dp_sh_d;
`endif
      if (frame) begin
        seen_q  <= '0;
        dig_q   <= shadow_d;
        blank_q <= blank_sh_d;
`ifdef SEG7_DP_EN
        dp_q    <= dp_sh_d;
`endif
      end else begin
        seen_q  <= seen_d;
      end
    end
  end

  assign oDIG   = dig_q;
  assign oBLANK = blank_q;
  assign oVALID = valid_q;
  assign oERR   = err_q;
`ifdef SEG7_DP_EN
  assign oDP    = dp_q;
`endif

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Recovers hex digits from a time-multiplexed, active-low 4-digit seven-segment bus (segments plus per-digit select strobes) and presents them as a 16-bit value. It is the decode-side counterpart of the board's hex-to-segment display path. It is used for loopback self-test of the DE1 display and for sniffing external multiplexed displays. Each digit is accepted only after a stability filter, invalid patterns are flagged, and a completed 4-digit frame is published with a one-cycle valid pulse.

## Interface
Parameters:
- STABLE_CNT, 4: consecutive identical samples required to accept a digit (2..255).
- SAMPLE_DIV, 1: sample one clock in every SAMPLE_DIV clocks (1..65535).

Ports (one clock; reset is asynchronous and active-high):
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous active-high reset.
- iSEG  in  7  segment lines, active-low, bit0=a … bit6=g; asynchronous to iCLK.
- iDIG_SEL  in  4  digit strobes, active-low one-hot, bit k = digit k (digit 0 = iDIG[3:0] nibble); asynchronous.
- iCLR_ERR  in  1  clears oERR (synchronous, one cycle).
- oDIG  out  16  last complete frame, digit k in bits [4k+3:4k].
- oBLANK  out  4  digit k was blank (1111111) in the last frame.
- oVALID  out  1  one-cycle pulse when oDIG/oBLANK update.
- oERR  out  4  sticky: digit k received a non-hex, non-blank pattern.

## Operation
- iSEG and iDIG_SEL pass through a 2-flop synchronizer; all logic uses the synchronized values.
- Sample enable: the divider counter runs 0..SAMPLE_DIV-1 and sampling occurs at terminal count. With SAMPLE_DIV=1, every cycle is a sample.
- Per sample:
  - Select not exactly one low bit (none, or two or more): sample ignored, stability counter cleared, accepted flag cleared.
  - Select index k differs from the previous sample, or pattern differs from the previous sample: counter set to 1, accepted flag cleared.
  - Same k and same pattern: counter increments and saturates at STABLE_CNT.
- Acceptance: when the counter reaches STABLE_CNT and the accepted flag is clear, the digit is accepted and the accepted flag is set. While the strobe is held, no re-acceptance occurs.
- Decode of an accepted pattern, using the standard DE1 table (0=1000000, 1=1111001, … 8=0000000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110):
  - Hex match: shadow[k] gets the nibble, blank bit cleared, seen[k] set.
  - 1111111: shadow[k] gets 0, blank bit set, seen[k] set.
  - Any other pattern: oERR[k] set, seen[k] unchanged.
- Frame: when seen becomes 4'b1111, including via the acceptance in that same cycle:
  - shadow, with the current write merged, goes to oDIG.
  - blank shadow goes to oBLANK.
  - oVALID pulses.
  - seen is cleared.
- Simultaneous oERR set and iCLR_ERR in the same cycle: set wins.

## Timing
- Reset values: oDIG=0, oBLANK=0, oVALID=0, oERR=0. Also cleared: seen, counter, accepted flag, divider, and synchronizers (synchronizers reset to all-ones, i.e. idle).
- Input change to synchronized value: 2 cycles.
- Acceptance occurs on the STABLE_CNT-th qualifying sample. The decode result and oVALID are registered, so outputs update on the next clock edge.
- With SAMPLE_DIV=1 and STABLE_CNT=4, a stable strobe produces an acceptance 2+4 cycles after its input edge, and outputs update 1 cycle later.
- Reset asserted mid-frame discards partial digits. No oVALID fires until four fresh digits have been accepted.
- A strobe shorter than STABLE_CNT samples is dropped silently, with no error.

## Configuration
- SEG7_DP_EN defined:
  - Adds input iDP (1 bit, active-low decimal point, synchronized with iSEG).
  - Adds output oDP (4 bits, reset 0), captured per digit and published with oDIG.
  - The DP value takes part in the stability compare.
- SEG7_DP_EN undefined: no iDP or oDP ports. Comparison uses iSEG only.

## Structure
- Shared package seg7_pkg holds:
  - the 16 segment pattern constants and SEG_BLANK;
  - SEG_W=7 and NDIG=4.
- Sub-module seg7_pattern_dec: combinational, 7-bit pattern in, nibble/valid/blank out. Instantiated once and fed by the current sample.
- The top level contains the synchronizers, divider, stability counter, shadow/seen registers and output registers.

## Test plan
- Clean scan: loop strobes 1110, 1101, 1011, 0111, each held 8 cycles, with patterns 3, 0, A, F (0110000, 1000000, 0001000, 0001110) -> oDIG=16'hFA03 and one oVALID pulse per full loop.
- Glitch: digit 2 held for 3 cycles only (STABLE_CNT=4) -> no acceptance, no oVALID until a full-length strobe arrives; oERR stays 0.
- Invalid pattern: digit 1 shows 1010101 -> oERR=4'b0010 and no oVALID. iCLR_ERR clears it; a following valid loop restores oVALID.
- Blank and illegal select: digit 3 shows 1111111 -> oBLANK=4'b1000 and nibble 0. Strobe 1100 for 10 cycles -> ignored, no state change.
- Reset mid-frame: assert iRST after digits 0–1 are accepted -> all outputs 0. The next oVALID occurs only after four new acceptances.
- SEG7_DP_EN build: iDP low on digit 0 only -> oDP=4'b0001. A DP toggle within a strobe restarts the stability count.
